// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: data width, register-file geometry and
// the writeback-source encoding used by the MEM/WB select.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t X0_IDX = '0;

  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

  // True for an address that names a real, writable register (never x0).
  function automatic logic reg_in_range(input reg_addr_t addr, input int num_regs);
    return (addr != X0_IDX) && (int'(addr) < num_regs);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback + decode read-port bundle for wb_regfile.
// master = pipeline/decode side, slave = register file.
interface wb_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic                                Mem_to_Reg;
  logic                                Reg_Write;
  logic [XLEN-1:0]                     Read_Data;
  logic [XLEN-1:0]                     ALU_Result;
  logic [31:0]                         RD;
  logic [riscv_pkg::REG_ADDR_W-1:0]    rs1_addr;
  logic [riscv_pkg::REG_ADDR_W-1:0]    rs2_addr;
  logic [XLEN-1:0]                     rs1_data;
  logic [XLEN-1:0]                     rs2_data;
  logic [XLEN-1:0]                     wb_data;
  logic [CNT_W-1:0]                    wb_count;
  logic [riscv_pkg::REG_ADDR_W-1:0]    last_rd;
  logic [XLEN-1:0]                     last_data;

  modport master (
    output Mem_to_Reg, Reg_Write, Read_Data, ALU_Result, RD, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_count, last_rd, last_data
  );

  modport slave (
    input  Mem_to_Reg, Reg_Write, Read_Data, ALU_Result, RD, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_count, last_rd, last_data
  );

endinterface

// File: rtl/wb_mux.sv
// Writeback source select: load data or ALU result, chosen by Mem_to_Reg.
// Purely combinational so decode can reuse it.
module wb_mux
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             mem_to_reg,
  input  logic [WIDTH-1:0] read_data,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] wb_data
);

  wb_sel_e sel;
  assign sel = wb_sel_e'(mem_to_reg);

  always_comb begin
    // NOTE: default assignment first so no path leaves wb_data unassigned (no latch).
    wb_data = alu_result;
    case (sel)
      WB_SEL_MEM: wb_data = read_data;
      default:    wb_data = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-side integer register file: commits MEM/WB results, serves two
// combinational read ports, and keeps a commit counter plus last-commit record.
// Optional write-through forwarding: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int CNT_W    = 32
) (
  input logic          clk,
  input logic          rst_n,
  wb_regfile_if.slave  bus
);

  import riscv_pkg::*;

  reg_addr_t        rd_idx;
  logic [XLEN-1:0]  wb_data;
  logic             commit;

  // Only RD[4:0] addresses the array; the upper destination bits carry nothing.
  logic unused_rd_hi;
  assign unused_rd_hi = ^bus.RD[31:REG_ADDR_W];

  assign rd_idx = bus.RD[REG_ADDR_W-1:0];
  assign commit = bus.Reg_Write && reg_in_range(rd_idx, NUM_REGS);

  wb_mux #(.WIDTH(XLEN)) u_wb_mux (
    .mem_to_reg (bus.Mem_to_Reg),
    .read_data  (bus.Read_Data),
    .alu_result (bus.ALU_Result),
    .wb_data    (wb_data)
  );

  assign bus.wb_data = wb_data;

  // ---------------------------------------------------------------------------
  // Register array. Entry 0 is held at zero and never written.
  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset because reads must return 0 during and right
      // after reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: non-blocking for all sequential state, so every flop samples
        // pre-edge values regardless of process ordering.
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[rd_idx] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit counter and last-commit trace record.
  logic [CNT_W-1:0]  wb_count_q;
  reg_addr_t         last_rd_q;
  logic [XLEN-1:0]   last_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_q  <= '0;
      last_rd_q   <= X0_IDX;
      last_data_q <= '0;
    end else if (commit) begin
      wb_count_q  <= wb_count_q + CNT_W'(1);
      last_rd_q   <= rd_idx;
      last_data_q <= wb_data;
    end
  end

  assign bus.wb_count  = wb_count_q;
  assign bus.last_rd   = last_rd_q;
  assign bus.last_data = last_data_q;

  // ---------------------------------------------------------------------------
  // Read ports, indexed 0 = rs1, 1 = rs2.
  reg_addr_t        rs_addr [2];
  logic [XLEN-1:0]  rs_data [2];

  assign rs_addr[0] = bus.rs1_addr;
  assign rs_addr[1] = bus.rs2_addr;

`ifdef WB_REGFILE_BYPASS_EN
  // Forwarding is suppressed while reset is held so reads stay at zero.
  logic fwd;
  assign fwd = commit && rst_n;
`endif

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = '0;
      if (reg_in_range(rs_addr[p], NUM_REGS)) begin
        rs_data[p] = regs[rs_addr[p]];
      end
`ifdef WB_REGFILE_BYPASS_EN
      if (fwd && (rs_addr[p] == rd_idx)) begin
        rs_data[p] = wb_data;
      end
`endif
    end
  end

  assign bus.rs1_data = rs_data[0];
  assign bus.rs2_data = rs_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: an architectural model checked every cycle,
// plus hand-computed expectations. A second instance with CNT_W=4 covers wrap.
module tb_wb_regfile;

  logic clk;
  logic rst_n;

  wb_regfile_if #(.XLEN(32), .CNT_W(32)) bus ();
  wb_regfile_if #(.XLEN(32), .CNT_W(4))  bus_w ();

  wb_regfile #(.XLEN(32), .NUM_REGS(32), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wb_regfile #(.XLEN(32), .NUM_REGS(32), .CNT_W(4)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  assign bus_w.Mem_to_Reg = bus.Mem_to_Reg;
  assign bus_w.Reg_Write  = bus.Reg_Write;
  assign bus_w.Read_Data  = bus.Read_Data;
  assign bus_w.ALU_Result = bus.ALU_Result;
  assign bus_w.RD         = bus.RD;
  assign bus_w.rs1_addr   = bus.rs1_addr;
  assign bus_w.rs2_addr   = bus.rs2_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Architectural model: plain array of register values and a commit tally.
  logic [31:0]     m_regs [32];
  longint unsigned m_commits;
  logic [4:0]      m_last_rd;
  logic [31:0]     m_last_data;

  function automatic logic [31:0] exp_wb();
    return bus.Mem_to_Reg ? bus.Read_Data : bus.ALU_Result;
  endfunction

  function automatic logic is_commit();
    return bus.Reg_Write && (bus.RD[4:0] != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (!rst_n || addr == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
    if (is_commit() && addr == bus.RD[4:0]) return exp_wb();
`endif
    return m_regs[addr];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_commits   <= 0;
      m_last_rd   <= 5'd0;
      m_last_data <= 32'h0;
    end else if (is_commit()) begin
      m_regs[bus.RD[4:0]] <= exp_wb();
      m_commits           <= m_commits + 1;
      m_last_rd           <= bus.RD[4:0];
      m_last_data         <= exp_wb();
    end
  end

  // Mid-cycle comparison of every output against the model.
  logic [63:0] cnt_full;
  logic [63:0] cnt_wrap;
  always @(negedge clk) begin
    cnt_full = {32'h0, m_commits[31:0]};
    cnt_wrap = {60'h0, m_commits[3:0]};
    check("cyc_wb_data",   bus.wb_data,    exp_wb());
    check("cyc_rs1_data",  bus.rs1_data,   exp_read(bus.rs1_addr));
    check("cyc_rs2_data",  bus.rs2_data,   exp_read(bus.rs2_addr));
    check("cyc_wb_count",  bus.wb_count,   cnt_full);
    check("cyc_last_rd",   bus.last_rd,    m_last_rd);
    check("cyc_last_data", bus.last_data,  m_last_data);
    check("cyc_cnt4",      bus_w.wb_count, cnt_wrap);
    check("cyc_cnt4_rd",   bus_w.last_rd,  m_last_rd);
  end

  // ---------------------------------------------------------------------------
  // Stimulus: drive one cycle's inputs 2 time units after the rising edge.
  task automatic step(input logic rw, input logic m2r, input logic [31:0] rdat,
                      input logic [31:0] alu, input logic [31:0] rd,
                      input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #2;
    bus.Reg_Write  = rw;
    bus.Mem_to_Reg = m2r;
    bus.Read_Data  = rdat;
    bus.ALU_Result = alu;
    bus.RD         = rd;
    bus.rs1_addr   = a1;
    bus.rs2_addr   = a2;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, a1, a2);
    #1;
  endtask

  logic [31:0] byp_exp;

  initial begin
    rst_n = 1'b0;
    bus.Reg_Write = 1'b0; bus.Mem_to_Reg = 1'b0; bus.Read_Data = '0;
    bus.ALU_Result = '0;  bus.RD = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_rs1",       bus.rs1_data,   32'h0);
    check("reset_count",     bus.wb_count,   32'h0);
    check("reset_last_rd",   bus.last_rd,    5'd0);
    check("reset_last_data", bus.last_data,  32'h0);

    // Basic ALU write to x5.
    step(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'd5, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    check("basic_rs1",       bus.rs1_data,  32'hDEADBEEF);
    check("basic_count",     bus.wb_count,  32'd1);
    check("basic_last_rd",   bus.last_rd,   5'd5);
    check("basic_last_data", bus.last_data, 32'hDEADBEEF);

    // Load select aimed at x0: dropped.
    step(1'b1, 1'b1, 32'h1234, 32'hFFFF, 32'd0, 5'd5, 5'd0);
    #1 check("load_wb_data", bus.wb_data, 32'h1234);
    idle(5'd5, 5'd0);
    check("x0_rs2",       bus.rs2_data,  32'h0);
    check("x0_count",     bus.wb_count,  32'd1);
    check("x0_last_rd",   bus.last_rd,   5'd5);
    check("x0_last_data", bus.last_data, 32'hDEADBEEF);

    // Reg_Write=0 changes nothing.
    step(1'b0, 1'b0, 32'h0, 32'h55, 32'd6, 5'd6, 5'd5);
    idle(5'd6, 5'd5);
    check("nowrite_x6",    bus.rs1_data, 32'h0);
    check("nowrite_count", bus.wb_count, 32'd1);

    // Upper RD bits ignored.
    step(1'b1, 1'b0, 32'h0, 32'hA5, 32'hFFFF_FFE7, 5'd7, 5'd7);
    idle(5'd7, 5'd5);
    check("rdhi_x7",      bus.rs1_data, 32'hA5);
    check("rdhi_last_rd", bus.last_rd,  5'd7);
    check("rdhi_count",   bus.wb_count, 32'd2);

    // Same-cycle read of a register being written.
    step(1'b1, 1'b0, 32'h0, 32'h11, 32'd9, 5'd0, 5'd0);
    step(1'b1, 1'b0, 32'h0, 32'h77, 32'd9, 5'd9, 5'd9);
`ifdef WB_REGFILE_BYPASS_EN
    byp_exp = 32'h77;
`else
    byp_exp = 32'h11;
`endif
    #1;
    check("bypass_rs1", bus.rs1_data, byp_exp);
    check("bypass_rs2", bus.rs2_data, byp_exp);
    idle(5'd9, 5'd9);
    check("after_rs1", bus.rs1_data, 32'h77);
    check("after_rs2", bus.rs2_data, 32'h77);

    // Mixed load/ALU writes, each read back the following cycle.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'(i % 2), 32'h1111_0000 * i, ~(32'h0 + i), 32'(i + 10),
           5'(i + 9), 5'd9);
    end
    idle(5'd11, 5'd12);
    check("mix_x11", bus.rs1_data, 32'h1111_0000);
    check("mix_x12", bus.rs2_data, 32'hFFFF_FFFD);

    // Asynchronous reset mid-cycle while a commit is pending.
    step(1'b1, 1'b0, 32'h0, 32'h99, 32'd3, 5'd5, 5'd7);
    #1 rst_n = 1'b0;
    #1;
    check("arst_rs1",       bus.rs1_data,   32'h0);
    check("arst_rs2",       bus.rs2_data,   32'h0);
    check("arst_count",     bus.wb_count,   32'h0);
    check("arst_count4",    bus_w.wb_count, 4'h0);
    check("arst_last_rd",   bus.last_rd,    5'd0);
    check("arst_last_data", bus.last_data,  32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd5);
    #1 rst_n = 1'b1;
    #1;
    check("arst_lost_x3", bus.rs1_data, 32'h0);
    check("arst_x5",      bus.rs2_data, 32'h0);

    // Counter wrap on the 4-bit instance: 17 commits.
    for (int k = 0; k < 17; k++) begin
      step(1'b1, 1'b0, 32'h0, 32'(k * 3 + 1), 32'((k % 31) + 1), 5'd1, 5'd2);
      #1;
      if (k == 15) check("wrap_at15", bus_w.wb_count, 4'd15);
      if (k == 16) check("wrap_at0",  bus_w.wb_count, 4'd0);
    end
    idle(5'd17, 5'd1);
    check("wrap_final4",  bus_w.wb_count, 4'd1);
    check("wrap_final32", bus.wb_count,   32'd17);
    check("wrap_x17",     bus.rs1_data,   32'd49);
    check("wrap_x1",      bus.rs2_data,   32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
